// File: rtl/player_guess_tx.sv
// player_guess_tx: screens keypad guesses, queues accepted letters in a FIFO
// and sends each one as a UART 8N1 frame on tx_serial.
`default_nettype none

module player_guess_tx #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int DEPTH        = 4
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       ready,
    input  logic [7:0] msg,
    input  logic       gameEnd,
    output logic       tx_serial,
    output logic       blue,
    output logic       full,
    output logic       err_LED
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CW-1:0] c_BAUD_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_BAUD_ONE  = c_CW'(1);
    localparam logic [c_AW:0]   c_PTR_ONE   = (c_AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              r_blue;
    logic              r_err;
    logic [25:0]       r_mask;
    logic              r_ge_q;
    logic [7:0]        r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;

    logic              w_empty;
    logic              w_full;
    logic              w_baud_last;
    logic              w_ge_rise;
    logic              w_can_pop;
    logic              w_pop;
    logic              w_commit;
    logic              w_letter;
    logic [4:0]        w_idx;
    logic              w_dup;
    logic              w_push;
    logic              w_reject;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                         (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_baud_last = (r_baud == c_BAUD_LAST);
    assign w_ge_rise   = gameEnd & ~r_ge_q;

    // The head leaves the FIFO when the line is idle or as a stop bit completes;
    // a gameEnd rising edge wins so a flushed letter is never sent.
    assign w_can_pop = (r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last);
    assign w_pop     = w_can_pop & ~w_empty & ~w_ge_rise;

    // 'A'..'Z' have low five bits 1..26, so subtracting one gives the mask index.
    assign w_commit = ready & ~gameEnd;
    assign w_letter = (msg >= 8'h41) && (msg <= 8'h5A);
    assign w_idx    = msg[4:0] - 5'd1;
    assign w_dup    = w_letter && r_mask[w_idx];
    assign w_push   = w_commit & w_letter & ~w_dup & (~w_full | w_pop);
    assign w_reject = w_commit & ~w_push;

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_baud_last) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_nxt = r_shift[r_bit_idx];
                if (w_baud_last && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    w_state_nxt = w_pop ? S_START : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_blue    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_blue  <= (r_state != S_IDLE) | ~w_empty;
            if ((r_state == S_IDLE) || w_baud_last) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + c_BAUD_ONE;
            end
            if ((r_state == S_DATA) && w_baud_last) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr[c_AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= msg;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_mask   <= '0;
            r_err    <= 1'b0;
            r_ge_q   <= 1'b0;
        end else begin
            r_ge_q <= gameEnd;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_ge_rise) begin
                r_rd_ptr <= r_wr_ptr;
                r_mask   <= '0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                if (w_push) begin
                    r_mask[w_idx] <= 1'b1;
                end
            end
            if (w_reject) begin
                r_err <= 1'b1;
            end else if (w_push) begin
                r_err <= 1'b0;
            end
        end
    end

    assign tx_serial = r_tx;
    assign blue      = r_blue;
    assign full      = w_full;
    assign err_LED   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_player_guess_tx.sv
// tb_player_guess_tx: table vectors, directed corner sequences and random
// stimulus checked cycle by cycle against a queue-based reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_player_guess_tx;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       nRst;
    logic       ready;
    logic [7:0] msg;
    logic       gameEnd;
    logic       tx_serial;
    logic       blue;
    logic       full;
    logic       err_LED;

    player_guess_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .ready     (ready),
        .msg       (msg),
        .gameEnd   (gameEnd),
        .tx_serial (tx_serial),
        .blue      (blue),
        .full      (full),
        .err_LED   (err_LED)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: the transmitter is a server that takes a letter from the
    // queue and is busy for FRAME cycles; line level = bit (offset / CPB) of it.
    logic [7:0]  m_q[$];
    logic [25:0] m_mask;
    logic        m_err;
    logic        m_prev_ge;
    int          m_cyc;
    int          m_last_pop;
    int          m_free_at;
    logic [7:0]  m_cur;
    logic [3:0]  m_exp;

    task automatic model_reset();
        m_q.delete();
        m_mask     = '0;
        m_err      = 1'b0;
        m_prev_ge  = 1'b0;
        m_cyc      = 0;
        m_last_pop = -1000000;
        m_free_at  = 0;
        m_cur      = '0;
        m_exp      = 4'b1000;
    endtask

    task automatic model_step();
        int   o;
        int   b;
        int   li;
        logic busy;
        logic tx_e;
        logic blue_e;
        logic ge_rise;
        logic pop;
        logic acc;
        if (!nRst) begin
            model_reset();
            return;
        end
        o      = m_cyc - 1 - m_last_pop;
        busy   = (o >= 0) && (o < FRAME);
        tx_e   = 1'b1;
        if (busy) begin
            b = o / CPB;
            if (b == 0) tx_e = 1'b0;
            else if (b <= 8) tx_e = m_cur[b-1];
        end
        blue_e  = busy || (m_q.size() != 0);
        ge_rise = gameEnd && !m_prev_ge;
        pop     = (m_q.size() != 0) && (m_cyc >= m_free_at) && !ge_rise;
        acc     = 1'b0;
        if (ge_rise) begin
            m_q.delete();
            m_mask = '0;
        end
        if (ready && !gameEnd) begin
            li = int'(msg) - 65;
            if (li < 0 || li > 25) m_err = 1'b1;
            else if (m_mask[li]) m_err = 1'b1;
            else if (m_q.size() == DEPTH && !pop) m_err = 1'b1;
            else begin
                acc       = 1'b1;
                m_err     = 1'b0;
                m_mask[li] = 1'b1;
            end
        end
        if (pop) begin
            m_cur      = m_q.pop_front();
            m_last_pop = m_cyc;
            m_free_at  = m_cyc + FRAME;
        end
        if (acc) m_q.push_back(msg);
        m_prev_ge = gameEnd;
        m_cyc++;
        m_exp = {tx_e, blue_e, (m_q.size() == DEPTH), m_err};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("cycle{tx,blue,full,err}", {4'b0, tx_serial, blue, full, err_LED}, {4'b0, m_exp});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [7:0] m);
        ready = 1'b1;
        msg   = m;
        tick(1);
        ready = 1'b0;
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        tick(3);
        nRst = 1'b1;
        tick(1);
    endtask

    typedef struct {
        logic       rdy;
        logic [7:0] m;
        logic       e_err;
        logic       e_full;
    } vec_t;

    vec_t       tbl [8];
    logic [9:0] a_bits;

    initial begin
        // Consecutive commits with the line busy: A leaves, B..E fill the FIFO.
        tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h43, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'h45, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 8'h46, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 8'h61, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 8'h42, 1'b1, 1'b1};
        a_bits = 10'b10_1000_0010;

        nRst    = 1'b0;
        ready   = 1'b0;
        msg     = 8'h00;
        gameEnd = 1'b0;
        tick(3);
        chk("reset tx", {7'b0, tx_serial}, 8'd1);
        chk("reset blue", {7'b0, blue}, 8'd0);
        chk("reset full", {7'b0, full}, 8'd0);
        chk("reset err", {7'b0, err_LED}, 8'd0);
        nRst = 1'b1;
        tick(2);

        // Single 'A' frame: start bit two edges after the commit.
        commit(8'h41);
        chk("A tx n", {7'b0, tx_serial}, 8'd1);
        tick(1);
        chk("A tx n+1", {7'b0, tx_serial}, 8'd1);
        chk("A blue n+1", {7'b0, blue}, 8'd1);
        tick(1);
        chk("A start edge", {7'b0, tx_serial}, 8'd0);
        for (int i = 0; i < 10; i++) begin
            tick(i == 0 ? CPB / 2 : CPB);
            chk($sformatf("A bit%0d", i), {7'b0, tx_serial}, {7'b0, a_bits[i]});
            chk($sformatf("A blue%0d", i), {7'b0, blue}, 8'd1);
        end
        tick(CPB / 2 - 1);
        chk("A blue end-1", {7'b0, blue}, 8'd1);
        tick(1);
        chk("A blue end", {7'b0, blue}, 8'd0);
        tick(10);

        // Table vectors from a fresh reset.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ready = tbl[i].rdy;
            msg   = tbl[i].m;
            tick(1);
            chk($sformatf("tbl%0d err", i), {7'b0, err_LED}, {7'b0, tbl[i].e_err});
            chk($sformatf("tbl%0d full", i), {7'b0, full}, {7'b0, tbl[i].e_full});
        end
        ready = 1'b0;
        tick(73);
        commit(8'h48);
        chk("full+pop err", {7'b0, err_LED}, 8'd0);
        chk("full+pop full", {7'b0, full}, 8'd1);
        tick(7 * FRAME);

        // Duplicate then a new letter.
        commit(8'h4B);
        tick(2);
        commit(8'h4B);
        chk("dup K err", {7'b0, err_LED}, 8'd1);
        commit(8'h4C);
        chk("L err", {7'b0, err_LED}, 8'd0);
        commit(8'h5B);
        chk("0x5B err", {7'b0, err_LED}, 8'd1);
        commit(8'h40);
        chk("0x40 err", {7'b0, err_LED}, 8'd1);
        tick(3 * FRAME);

        // gameEnd mid-frame: frame completes, queue flushed, mask cleared.
        commit(8'h4D);
        commit(8'h4E);
        commit(8'h4F);
        tick(30);
        gameEnd = 1'b1;
        tick(1);
        chk("ge blue", {7'b0, blue}, 8'd1);
        ready = 1'b1;
        msg   = 8'h50;
        tick(1);
        ready = 1'b0;
        chk("ge ignore err", {7'b0, err_LED}, 8'd0);
        tick(FRAME);
        chk("ge blue off", {7'b0, blue}, 8'd0);
        chk("ge tx idle", {7'b0, tx_serial}, 8'd1);
        gameEnd = 1'b0;
        tick(2);
        commit(8'h4D);
        chk("M again err", {7'b0, err_LED}, 8'd0);
        tick(2);
        chk("M again blue", {7'b0, blue}, 8'd1);
        tick(FRAME + 10);

        // Reset in the middle of a data bit.
        commit(8'h51);
        commit(8'h51);
        tick(30);
        #3;
        nRst = 1'b0;
        #1;
        chk("mid rst tx", {7'b0, tx_serial}, 8'd1);
        chk("mid rst blue", {7'b0, blue}, 8'd0);
        chk("mid rst full", {7'b0, full}, 8'd0);
        chk("mid rst err", {7'b0, err_LED}, 8'd0);
        tick(2);
        nRst = 1'b1;
        tick(FRAME);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int r;
            @(negedge clk);
            ready = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 99);
            if (r < 70) msg = 8'(8'h41 + $urandom_range(0, 9));
            else if (r < 85) msg = 8'($urandom);
            else msg = 8'(8'h41 + $urandom_range(0, 25));
            if ($urandom_range(0, 299) == 0) gameEnd = ~gameEnd;
            nRst = ($urandom_range(0, 1999) != 0);
        end
        @(negedge clk);
        ready   = 1'b0;
        nRst    = 1'b1;
        gameEnd = 1'b0;
        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
